// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram counter (uPC) and next-address selection
// for the control store. Picks increment, MIR jump target or opcode decode
// from the branch-type (Tipo) bus, holds while memory is not ready, and
// freezes in HALT on a fatal sequencing error until the next reset.
//
// Stall semantics: Stall_In is a level "not ready" indication rather than a
// valid/ready handshake. While it is high in RUN the uPC holds and Tipo is
// ignored. The Tipo of the held microinstruction is applied on the first RUN
// edge after the sequencer has returned from STALL.
module micro_sequencer #(
  parameter int MICRO_SEQUENCER_ADDR = 11,
  parameter int MICRO_SEQUENCER_TIPO = 2,
  parameter int MICRO_SEQUENCER_IR   = 32
) (
  input  logic                            MICRO_SEQUENCER_CLOCK_50,
  input  logic                            MICRO_SEQUENCER_ResetInLow_In,
  input  logic [MICRO_SEQUENCER_TIPO-1:0] MICRO_SEQUENCER_Tipo_InBus,
  input  logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_JumpAddr_InBus,
  input  logic [MICRO_SEQUENCER_IR-1:0]   MICRO_SEQUENCER_IR_InBus,
  input  logic                            MICRO_SEQUENCER_Stall_In,
  output logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_Addr_OutBus,
  output logic                            MICRO_SEQUENCER_Stalled_Out,
  output logic                            MICRO_SEQUENCER_Halt_Out,
  output logic [1:0]                      MICRO_SEQUENCER_Error_OutBus,
  // Debug view of the sequencer state: 0 BOOT, 1 RUN, 2 STALL, 3 HALT
  output logic [1:0]                      MICRO_SEQUENCER_State_OutBus
);

  // Branch-type encodings carried on the Tipo bus
  localparam logic [1:0] TIPO_NEXT   = 2'b00;
  localparam logic [1:0] TIPO_JUMP   = 2'b01;
  localparam logic [1:0] TIPO_DECODE = 2'b10;

  // Error codes reported while halted
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIPO     = 2'b01;
  localparam logic [1:0] ERR_OPCODE   = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  // Format-2 op2 values that have a microcode routine
  localparam logic [2:0] OP2_BRANCH = 3'b010;
  localparam logic [2:0] OP2_SETHI  = 3'b100;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t                          state;
  logic [MICRO_SEQUENCER_ADDR-1:0] upc;
  logic                            stalled;
  logic                            halt;
  logic [1:0]                      error;

  // Decoder outputs
  logic [1:0]                      op;
  logic [2:0]                      op2;
  logic [MICRO_SEQUENCER_ADDR-1:0] decode_addr;
  logic                            decode_legal;

  // Overflow detection for the increment path (no wrap allowed)
  logic                            upc_at_max;

  assign op  = MICRO_SEQUENCER_IR_InBus[31:30];
  assign op2 = MICRO_SEQUENCER_IR_InBus[24:22];
  assign upc_at_max = (upc == {MICRO_SEQUENCER_ADDR{1'b1}});

  // Opcode decode: map the instruction to the entry point of its routine.
  // All routines live in the upper half of the control store (MSB = 1).
  always_comb begin
    decode_addr  = '0;
    decode_legal = 1'b0;
    if (op[1]) begin
      // Format 3: one routine per op/op3 pair, 4 words apart
      decode_addr  = {1'b1, op, MICRO_SEQUENCER_IR_InBus[24:19], 2'b00};
      decode_legal = 1'b1;
    end else if (op == 2'b00) begin
      // Format 2: one routine per op2, 32 words apart; only branch and sethi exist
      decode_addr  = {1'b1, 2'b00, op2, 5'b00000};
      decode_legal = (op2 == OP2_BRANCH) || (op2 == OP2_SETHI);
    end else begin
      // Format 1 (call): a single routine
      decode_addr  = {1'b1, 2'b01, 8'h00};
      decode_legal = 1'b1;
    end
  end

  // Sequencer FSM: uPC, state and all status outputs update together
  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In) begin
    if (!MICRO_SEQUENCER_ResetInLow_In) begin
      state   <= ST_BOOT;
      upc     <= '0;
      stalled <= 1'b0;
      halt    <= 1'b0;
      error   <= ERR_NONE;
    end else begin
      case (state)
        ST_BOOT: begin
          // uPC stays at 0 for one full cycle so the first word is fetched
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (MICRO_SEQUENCER_Stall_In) begin
            // Stall wins over Tipo; no error checks on a stalled cycle
            state   <= ST_STALL;
            stalled <= 1'b1;
          end else begin
            case (MICRO_SEQUENCER_Tipo_InBus)
              TIPO_NEXT: begin
                if (upc_at_max) begin
                  state <= ST_HALT;
                  halt  <= 1'b1;
                  error <= ERR_OVERFLOW;
                end else begin
                  upc <= upc + 1'b1;
                end
              end
              TIPO_JUMP: begin
                upc <= MICRO_SEQUENCER_JumpAddr_InBus;
              end
              TIPO_DECODE: begin
                if (decode_legal) begin
                  upc <= decode_addr;
                end else begin
                  state <= ST_HALT;
                  halt  <= 1'b1;
                  error <= ERR_OPCODE;
                end
              end
              default: begin
                // Reserved branch type
                state <= ST_HALT;
                halt  <= 1'b1;
                error <= ERR_TIPO;
              end
            endcase
          end
        end

        ST_STALL: begin
          // Hold the current microinstruction until memory is ready
          if (!MICRO_SEQUENCER_Stall_In) begin
            state   <= ST_RUN;
            stalled <= 1'b0;
          end
        end

        default: begin
          // HALT: everything frozen until reset
          state <= ST_HALT;
        end
      endcase
    end
  end

  assign MICRO_SEQUENCER_Addr_OutBus  = upc;
  assign MICRO_SEQUENCER_Stalled_Out  = stalled;
  assign MICRO_SEQUENCER_Halt_Out     = halt;
  assign MICRO_SEQUENCER_Error_OutBus = error;
  assign MICRO_SEQUENCER_State_OutBus = state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer. Inputs change #1 after each
// posedge and outputs are checked there, well away from the active edge.
module tb_micro_sequencer;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  tipo;
  logic [10:0] jump_addr;
  logic [31:0] ir;
  logic        stall;
  logic [10:0] addr;
  logic        stalled;
  logic        halt;
  logic [1:0]  error;
  logic [1:0]  state;

  int total;
  int bad;

  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50       (clk),
    .MICRO_SEQUENCER_ResetInLow_In  (rst_n),
    .MICRO_SEQUENCER_Tipo_InBus     (tipo),
    .MICRO_SEQUENCER_JumpAddr_InBus (jump_addr),
    .MICRO_SEQUENCER_IR_InBus       (ir),
    .MICRO_SEQUENCER_Stall_In       (stall),
    .MICRO_SEQUENCER_Addr_OutBus    (addr),
    .MICRO_SEQUENCER_Stalled_Out    (stalled),
    .MICRO_SEQUENCER_Halt_Out       (halt),
    .MICRO_SEQUENCER_Error_OutBus   (error),
    .MICRO_SEQUENCER_State_OutBus   (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and checks land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [10:0] j, input logic [31:0] i,
                       input logic s);
    tipo      = t;
    jump_addr = j;
    ir        = i;
    stall     = s;
  endtask

  task automatic check_status(input string tag, input logic [10:0] a, input logic st,
                              input logic h, input logic [1:0] e, input logic [1:0] fsm);
    check({tag, "_addr"}, 32'(addr), 32'(a));
    check({tag, "_stalled"}, 32'(stalled), 32'(st));
    check({tag, "_halt"}, 32'(halt), 32'(h));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_state"}, 32'(state), 32'(fsm));
  endtask

  // Reset, release on a non-edge time, and leave the sequencer in BOOT
  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 11'h000, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(2'b00, 11'h000, 32'h0, 1'b0);

    // T1: reset values, BOOT, then three increments
    tick();
    check_status("t1_reset", 11'h000, 1'b0, 1'b0, 2'b00, S_BOOT);
    rst_n = 1'b1;
    check_status("t1_boot", 11'h000, 1'b0, 1'b0, 2'b00, S_BOOT);
    tick();
    check_status("t1_run0", 11'h000, 1'b0, 1'b0, 2'b00, S_RUN);
    tick();
    check("t1_inc1", 32'(addr), 32'h1);
    tick();
    check("t1_inc2", 32'(addr), 32'h2);
    tick();
    check_status("t1_inc3", 11'h003, 1'b0, 1'b0, 2'b00, S_RUN);

    // T2: from uPC=5, jump then decode
    tick();
    tick();
    check("t2_upc5", 32'(addr), 32'h5);
    drive(2'b01, 11'h2A0, 32'h0, 1'b0);
    tick();
    check("t2_jump", 32'(addr), 32'h2A0);
    // IR=0x8A004002: op=10, IR[24:19]=000000 -> {1,10,000000,00} = 0x600
    drive(2'b10, 11'h000, 32'h8A00_4002, 1'b0);
    tick();
    check("t2_dec_fmt3", 32'(addr), 32'h600);
    // op=11, IR[24:19]=111111 -> {1,11,111111,00} = 0x7FC
    drive(2'b10, 11'h000, 32'hC1F8_0000, 1'b0);
    tick();
    check("t2_dec_op11", 32'(addr), 32'h7FC);
    // call: op=01 -> {1,01,00000000} = 0x500
    drive(2'b10, 11'h000, 32'h4000_0000, 1'b0);
    tick();
    check("t2_dec_call", 32'(addr), 32'h500);
    // sethi: op=00, op2=100 -> {1,00,100,00000} = 0x480
    drive(2'b10, 11'h000, 32'h0100_0000, 1'b0);
    tick();
    check("t2_dec_sethi", 32'(addr), 32'h480);
    // branch: op=00, op2=010 -> {1,00,010,00000} = 0x440
    drive(2'b10, 11'h000, 32'h0080_0000, 1'b0);
    tick();
    check_status("t2_dec_branch", 11'h440, 1'b0, 1'b0, 2'b00, S_RUN);

    // T3: stall at uPC=7 for three cycles with a pending jump
    drive(2'b01, 11'h007, 32'h0, 1'b0);
    tick();
    check("t3_upc7", 32'(addr), 32'h7);
    drive(2'b01, 11'h123, 32'h0, 1'b1);
    tick();
    check_status("t3_stall1", 11'h007, 1'b1, 1'b0, 2'b00, S_STALL);
    tick();
    check_status("t3_stall2", 11'h007, 1'b1, 1'b0, 2'b00, S_STALL);
    tick();
    check_status("t3_stall3", 11'h007, 1'b1, 1'b0, 2'b00, S_STALL);
    stall = 1'b0;
    tick();
    check_status("t3_resume", 11'h007, 1'b0, 1'b0, 2'b00, S_RUN);
    tick();
    check_status("t3_jump", 11'h123, 1'b0, 1'b0, 2'b00, S_RUN);

    // T4: illegal format-2 opcode halts; later activity is ignored
    drive(2'b10, 11'h000, 32'h0000_0000, 1'b0);
    tick();
    check_status("t4_illegal", 11'h123, 1'b0, 1'b1, 2'b10, S_HALT);
    drive(2'b01, 11'h055, 32'h0, 1'b1);
    tick();
    drive(2'b00, 11'h055, 32'h0, 1'b0);
    tick();
    drive(2'b11, 11'h055, 32'h0, 1'b0);
    tick();
    check_status("t4_frozen", 11'h123, 1'b0, 1'b1, 2'b10, S_HALT);
    rst_n = 1'b0;
    #1;
    check_status("t4_reset", 11'h000, 1'b0, 1'b0, 2'b00, S_BOOT);

    // T5a: increment at the top of the address space halts with overflow
    do_reset();
    tick();
    check("t5_boot_done", 32'(state), 32'(S_RUN));
    drive(2'b01, 11'h7FF, 32'h0, 1'b0);
    tick();
    check("t5_at_max", 32'(addr), 32'h7FF);
    drive(2'b00, 11'h000, 32'h0, 1'b0);
    tick();
    check_status("t5_overflow", 11'h7FF, 1'b0, 1'b1, 2'b11, S_HALT);

    // T5b: reserved Tipo halts
    do_reset();
    tick();
    drive(2'b11, 11'h000, 32'h0, 1'b0);
    tick();
    check_status("t5_reserved", 11'h000, 1'b0, 1'b1, 2'b01, S_HALT);

    // BOOT ignores Tipo: a jump presented during BOOT is not taken
    do_reset();
    drive(2'b01, 11'h3C3, 32'h0, 1'b0);
    tick();
    check_status("boot_ignores_tipo", 11'h000, 1'b0, 1'b0, 2'b00, S_RUN);

    // T6: asynchronous reset mid-STALL, between clock edges
    drive(2'b01, 11'h055, 32'h0, 1'b0);
    tick();
    check("t6_jump", 32'(addr), 32'h055);
    stall = 1'b1;
    tick();
    check_status("t6_stalled", 11'h055, 1'b1, 1'b0, 2'b00, S_STALL);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("t6_async_clear", 11'h000, 1'b0, 1'b0, 2'b00, S_BOOT);
    drive(2'b00, 11'h000, 32'h0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    check_status("t6_boot_done", 11'h000, 1'b0, 1'b0, 2'b00, S_RUN);
    tick();
    check("t6_inc", 32'(addr), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
